// File: rtl/psadd_arbiter.sv
// Two-requester round-robin front end for one shared packed saturating byte add/sub unit.
// Each requester owns a registered result slot with rvalid/rready and a saturation event counter.
module psadd_arbiter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [15:0]      r0_a,
    input  logic [15:0]      r0_b,
    input  logic             r0_sub,
    output logic             r0_rvalid,
    input  logic             r0_rready,
    output logic [15:0]      r0_rdata,
    output logic [1:0]       r0_sat,
    output logic [CNT_W-1:0] r0_satcnt,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [15:0]      r1_a,
    input  logic [15:0]      r1_b,
    input  logic             r1_sub,
    output logic             r1_rvalid,
    input  logic             r1_rready,
    output logic [15:0]      r1_rdata,
    output logic [1:0]       r1_sat,
    output logic [CNT_W-1:0] r1_satcnt
);

    localparam int unsigned LANE_W = 8;
    localparam int unsigned DATA_W = 2 * LANE_W;

    // Returns {sat, result}; the 9-bit intermediate holds every sum/difference exactly.
    function automatic logic [LANE_W:0] sat_lane(input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b,
                                                  input logic              sub);
        logic [LANE_W:0] ea;
        logic [LANE_W:0] eb;
        logic [LANE_W:0] s;
        ea = {a[LANE_W-1], a};
        eb = {b[LANE_W-1], b};
        s  = sub ? (ea - eb) : (ea + eb);
        if (s[LANE_W:LANE_W-1] == 2'b01) begin
            sat_lane = {1'b1, 8'h7F};
        end else if (s[LANE_W:LANE_W-1] == 2'b10) begin
            sat_lane = {1'b1, 8'h80};
        end else begin
            sat_lane = {1'b0, s[LANE_W-1:0]};
        end
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        cnt_inc = (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    logic              r0_rvalid_q, r0_rvalid_d;
    logic [DATA_W-1:0] r0_rdata_q,  r0_rdata_d;
    logic [1:0]        r0_sat_q,    r0_sat_d;
    logic [CNT_W-1:0]  r0_satcnt_q, r0_satcnt_d;
    logic              r1_rvalid_q, r1_rvalid_d;
    logic [DATA_W-1:0] r1_rdata_q,  r1_rdata_d;
    logic [1:0]        r1_sat_q,    r1_sat_d;
    logic [CNT_W-1:0]  r1_satcnt_q, r1_satcnt_d;
    logic              last_grant_q, last_grant_d;

    logic              elig0, elig1;
    logic              gnt0, gnt1;
    logic [DATA_W-1:0] op_a, op_b;
    logic              op_sub;
    logic [LANE_W:0]   lane_hi, lane_lo;
    logic [DATA_W-1:0] res_data;
    logic [1:0]        res_sat;

    // Round-robin grant: a slot is eligible if empty or draining this cycle.
    always_comb begin
        elig0 = r0_valid && (!r0_rvalid_q || r0_rready);
        elig1 = r1_valid && (!r1_rvalid_q || r1_rready);
        gnt0  = !rst && elig0 && (!elig1 || last_grant_q);
        gnt1  = !rst && elig1 && (!elig0 || !last_grant_q);
    end

    assign r0_ready = gnt0;
    assign r1_ready = gnt1;

    // Single shared datapath fed by the granted requester.
    always_comb begin
        op_a     = gnt1 ? r1_a   : r0_a;
        op_b     = gnt1 ? r1_b   : r0_b;
        op_sub   = gnt1 ? r1_sub : r0_sub;
        lane_hi  = sat_lane(op_a[15:8], op_b[15:8], op_sub);
        lane_lo  = sat_lane(op_a[7:0],  op_b[7:0],  op_sub);
        res_data = {lane_hi[LANE_W-1:0], lane_lo[LANE_W-1:0]};
        res_sat  = {lane_hi[LANE_W], lane_lo[LANE_W]};
    end

    // Slot update: drain first, then a new acceptance overrides it.
    always_comb begin
        r0_rvalid_d  = r0_rvalid_q;
        r0_rdata_d   = r0_rdata_q;
        r0_sat_d     = r0_sat_q;
        r0_satcnt_d  = r0_satcnt_q;
        r1_rvalid_d  = r1_rvalid_q;
        r1_rdata_d   = r1_rdata_q;
        r1_sat_d     = r1_sat_q;
        r1_satcnt_d  = r1_satcnt_q;
        last_grant_d = last_grant_q;

        if (r0_rvalid_q && r0_rready) r0_rvalid_d = 1'b0;
        if (r1_rvalid_q && r1_rready) r1_rvalid_d = 1'b0;

        if (gnt0) begin
            r0_rvalid_d  = 1'b1;
            r0_rdata_d   = res_data;
            r0_sat_d     = res_sat;
            last_grant_d = 1'b0;
            if (|res_sat) r0_satcnt_d = cnt_inc(r0_satcnt_q);
        end
        if (gnt1) begin
            r1_rvalid_d  = 1'b1;
            r1_rdata_d   = res_data;
            r1_sat_d     = res_sat;
            last_grant_d = 1'b1;
            if (|res_sat) r1_satcnt_d = cnt_inc(r1_satcnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r0_rvalid_q  <= 1'b0;
            r0_rdata_q   <= '0;
            r0_sat_q     <= '0;
            r0_satcnt_q  <= '0;
            r1_rvalid_q  <= 1'b0;
            r1_rdata_q   <= '0;
            r1_sat_q     <= '0;
            r1_satcnt_q  <= '0;
            last_grant_q <= 1'b1;
        end else begin
            r0_rvalid_q  <= r0_rvalid_d;
            r0_rdata_q   <= r0_rdata_d;
            r0_sat_q     <= r0_sat_d;
            r0_satcnt_q  <= r0_satcnt_d;
            r1_rvalid_q  <= r1_rvalid_d;
            r1_rdata_q   <= r1_rdata_d;
            r1_sat_q     <= r1_sat_d;
            r1_satcnt_q  <= r1_satcnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign r0_rvalid = r0_rvalid_q;
    assign r0_rdata  = r0_rdata_q;
    assign r0_sat    = r0_sat_q;
    assign r0_satcnt = r0_satcnt_q;
    assign r1_rvalid = r1_rvalid_q;
    assign r1_rdata  = r1_rdata_q;
    assign r1_sat    = r1_sat_q;
    assign r1_satcnt = r1_satcnt_q;

endmodule

// File: tb/tb_psadd_arbiter.sv
// Directed bench for psadd_arbiter: arithmetic corners, round-robin, backpressure, counter, reset.
module tb_psadd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r0_ready, r0_sub, r0_rvalid, r0_rready;
    logic [15:0] r0_a, r0_b, r0_rdata;
    logic [1:0]  r0_sat;
    logic [7:0]  r0_satcnt;
    logic        r1_valid, r1_ready, r1_sub, r1_rvalid, r1_rready;
    logic [15:0] r1_a, r1_b, r1_rdata;
    logic [1:0]  r1_sat;
    logic [7:0]  r1_satcnt;

    int n_tests = 0;
    int n_fail  = 0;

    psadd_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_sub(r0_sub),
        .r0_rvalid(r0_rvalid), .r0_rready(r0_rready), .r0_rdata(r0_rdata), .r0_sat(r0_sat),
        .r0_satcnt(r0_satcnt),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_sub(r1_sub),
        .r1_rvalid(r1_rvalid), .r1_rready(r1_rready), .r1_rdata(r1_rdata), .r1_sat(r1_sat),
        .r1_satcnt(r1_satcnt)
    );

    always #5 clk = ~clk;

    task automatic drive0(input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic rr);
        r0_valid = v; r0_a = a; r0_b = b; r0_sub = sub; r0_rready = rr;
    endtask

    task automatic drive1(input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic rr);
        r1_valid = v; r1_a = a; r1_b = b; r1_sub = sub; r1_rready = rr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive0(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        drive1(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive0(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1);
        drive1(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b1);
        #1;
        n_tests++;
        if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b%b want 00", r0_ready, r1_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (r0_rvalid !== 1'b0 || r0_rdata !== 16'h0 || r0_sat !== 2'b00 || r0_satcnt !== 8'h0 ||
            r1_rvalid !== 1'b0 || r1_rdata !== 16'h0 || r1_sat !== 2'b00 || r1_satcnt !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_state: r0 %b %h %b %h r1 %b %h %b %h want all zero",
                     r0_rvalid, r0_rdata, r0_sat, r0_satcnt, r1_rvalid, r1_rdata, r1_sat, r1_satcnt);
        end
        @(negedge clk);
        drive0(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        drive1(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    task automatic test_add_r0();
        @(negedge clk);
        drive0(1'b1, 16'h7F01, 16'h0101, 1'b0, 1'b1);
        #1;
        n_tests++;
        if (r0_ready !== 1'b1) begin
            n_fail++; $display("FAIL add_r0_ready: got %b want 1", r0_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (r0_rvalid !== 1'b1 || r0_rdata !== 16'h7F02 || r0_sat !== 2'b10 || r0_satcnt !== 8'd1) begin
            n_fail++;
            $display("FAIL add_r0: got v=%b d=%h s=%b c=%h want 1 7f02 10 01",
                     r0_rvalid, r0_rdata, r0_sat, r0_satcnt);
        end
        @(negedge clk);
        drive0(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        @(posedge clk); #1;
        n_tests++;
        if (r0_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL drain_r0: got rvalid=%b want 0", r0_rvalid);
        end
    endtask

    task automatic test_add_r1();
        @(negedge clk);
        drive1(1'b1, 16'h0070, 16'h0020, 1'b0, 1'b1);
        @(posedge clk); #1;
        n_tests++;
        if (r1_rvalid !== 1'b1 || r1_rdata !== 16'h007F || r1_sat !== 2'b01) begin
            n_fail++;
            $display("FAIL add_r1_pos: got v=%b d=%h s=%b want 1 007f 01", r1_rvalid, r1_rdata, r1_sat);
        end
        @(negedge clk);
        drive1(1'b1, 16'hFF90, 16'h0090, 1'b0, 1'b1);
        @(posedge clk); #1;
        n_tests++;
        if (r1_rvalid !== 1'b1 || r1_rdata !== 16'hFF80 || r1_sat !== 2'b01 || r1_satcnt !== 8'd2) begin
            n_fail++;
            $display("FAIL add_r1_neg: got v=%b d=%h s=%b c=%h want 1 ff80 01 02",
                     r1_rvalid, r1_rdata, r1_sat, r1_satcnt);
        end
        @(negedge clk);
        drive1(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic test_sub_r0();
        @(negedge clk);
        drive0(1'b1, 16'h8005, 16'h0106, 1'b1, 1'b1);
        @(posedge clk); #1;
        n_tests++;
        if (r0_rdata !== 16'h80FF || r0_sat !== 2'b10) begin
            n_fail++; $display("FAIL sub_r0_a: got d=%h s=%b want 80ff 10", r0_rdata, r0_sat);
        end
        @(negedge clk);
        drive0(1'b1, 16'h0000, 16'h8080, 1'b1, 1'b1);
        @(posedge clk); #1;
        n_tests++;
        if (r0_rdata !== 16'h7F7F || r0_sat !== 2'b11 || r0_satcnt !== 8'd3) begin
            n_fail++;
            $display("FAIL sub_r0_b: got d=%h s=%b c=%h want 7f7f 11 03", r0_rdata, r0_sat, r0_satcnt);
        end
        @(negedge clk);
        drive0(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive0(1'b1, 16'h0102, 16'h0304, 1'b0, 1'b1);
        drive1(1'b1, 16'h1000, 16'h0001, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (r0_ready !== ((i % 2) == 0) || r1_ready !== ((i % 2) == 1)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got r0=%b r1=%b want r0=%b r1=%b",
                         i, r0_ready, r1_ready, (i % 2) == 0, (i % 2) == 1);
            end
            @(negedge clk);
        end
        n_tests++;
        if (r0_rdata !== 16'h0406 || r1_rdata !== 16'h1001 || r0_rvalid !== 1'b0 || r1_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_data: got r0 %b %h r1 %b %h want 0 0406 1 1001",
                     r0_rvalid, r0_rdata, r1_rvalid, r1_rdata);
        end
        drive0(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        drive1(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        drive0(1'b1, 16'h0102, 16'h0304, 1'b0, 1'b0);
        @(negedge clk);
        n_tests++;
        if (r0_rvalid !== 1'b1 || r0_rdata !== 16'h0406) begin
            n_fail++; $display("FAIL bp_load: got v=%b d=%h want 1 0406", r0_rvalid, r0_rdata);
        end
        drive0(1'b1, 16'h5555, 16'h1111, 1'b0, 1'b0);
        drive1(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (r0_ready !== 1'b0 || r1_ready !== 1'b1 || r0_rdata !== 16'h0406 || r0_rvalid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_stall[%0d]: got r0_ready=%b r1_ready=%b d=%h v=%b want 0 1 0406 1",
                         i, r0_ready, r1_ready, r0_rdata, r0_rvalid);
            end
            @(negedge clk);
        end
        drive0(1'b1, 16'h0010, 16'h0020, 1'b0, 1'b1);
        #1;
        n_tests++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: got r0=%b r1=%b want 1 0", r0_ready, r1_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (r0_rvalid !== 1'b1 || r0_rdata !== 16'h0030 || r0_sat !== 2'b00) begin
            n_fail++; $display("FAIL bp_newdata: got v=%b d=%h s=%b want 1 0030 00", r0_rvalid, r0_rdata, r0_sat);
        end
        @(negedge clk);
        drive0(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        drive1(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic test_sat_counter();
        do_reset();
        drive0(1'b1, 16'h7F7F, 16'h0101, 1'b0, 1'b1);
        for (int i = 0; i < 254; i++) @(negedge clk);
        n_tests++;
        if (r0_satcnt !== 8'hFE) begin
            n_fail++; $display("FAIL satcnt_254: got %h want fe", r0_satcnt);
        end
        for (int i = 0; i < 46; i++) @(negedge clk);
        n_tests++;
        if (r0_satcnt !== 8'hFF || r0_rdata !== 16'h7F7F || r0_sat !== 2'b11) begin
            n_fail++;
            $display("FAIL satcnt_300: got c=%h d=%h s=%b want ff 7f7f 11", r0_satcnt, r0_rdata, r0_sat);
        end
        drive0(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        n_tests++;
        if (r0_rvalid !== 1'b1) begin
            n_fail++; $display("FAIL mid_pending: got rvalid=%b want 1", r0_rvalid);
        end
        rst = 1'b1;
        drive0(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b1);
        drive1(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b1);
        #1;
        n_tests++;
        if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_ready: got %b%b want 00", r0_ready, r1_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (r0_rvalid !== 1'b0 || r0_satcnt !== 8'h0) begin
            n_fail++; $display("FAIL mid_rst_state: got v=%b c=%h want 0 00", r0_rvalid, r0_satcnt);
        end
        #1;
        n_tests++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_tie: got r0=%b r1=%b want 1 0", r0_ready, r1_ready);
        end
        @(negedge clk);
        drive0(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        drive1(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        drive0(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        drive1(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        test_reset();
        test_add_r0();
        test_add_r1();
        test_sub_r0();
        test_back_to_back();
        test_backpressure();
        test_sat_counter();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
